// File: rtl/pipe_ctrl.sv
// Pipeline control unit: sequences stall, flush, branch-shadow kill and idle
// for a STAGES-deep in-order pipeline, and produces the redirect PC.
module pipe_ctrl #(
  parameter int                 STAGES     = 7,
  parameter int                 ADDR_W     = 32,
  parameter int                 ECODE_W    = 4,
  parameter int                 BR_KILL    = 1,
  parameter logic [ADDR_W-1:0]  EXC_BASE   = 'h0000_000c,
  parameter logic [ADDR_W-1:0]  VEC_STRIDE = 'h40,
  parameter logic [ECODE_W-1:0] INT_CODE   = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [STAGES-1:0]  stallreq_i,
  input  logic               branch_i,
  input  logic               excp_valid_i,
  input  logic [ECODE_W-1:0] excp_code_i,
  input  logic               ertn_i,
  input  logic [ADDR_W-1:0]  era_i,
  input  logic               idle_i,
  input  logic               int_i,
  output logic [STAGES-1:0]  stall_o,
  output logic               flush_o,
  output logic [ADDR_W-1:0]  new_pc_o,
  output logic               pc_kill_o,
  output logic               if_kill_o,
  output logic [1:0]         state_o
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    KILL  = 2'd1,
    FLUSH = 2'd2,
    IDLE  = 2'd3
  } state_t;

  localparam int KW = $clog2(BR_KILL + 1);
  localparam logic [KW-1:0] KILL_LOAD = KW'(BR_KILL);

  state_t             r_state, w_nextState;
  logic [KW-1:0]      r_killCnt, w_nextKillCnt;
  logic [STAGES-1:0]  r_stall, w_nextStall, w_stallMask;
  logic               r_flush, w_nextFlush;
  logic [ADDR_W-1:0]  r_newPc, w_nextPc, w_excVec, w_intVec;

  assign w_excVec = EXC_BASE + ADDR_W'(excp_code_i) * VEC_STRIDE;
  assign w_intVec = EXC_BASE + ADDR_W'(INT_CODE) * VEC_STRIDE;

  // Every stage upstream of the deepest requester must freeze as well.
  always_comb begin : stallSmear
    logic acc;
    acc = 1'b0;
    w_stallMask = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      acc = acc | stallreq_i[i];
      w_stallMask[i] = acc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= RUN;
      r_killCnt <= '0;
      r_stall   <= '0;
      r_flush   <= 1'b0;
      r_newPc   <= '0;
    end else begin
      r_state   <= w_nextState;
      r_killCnt <= w_nextKillCnt;
      r_stall   <= w_nextStall;
      r_flush   <= w_nextFlush;
      r_newPc   <= w_nextPc;
    end
  end

  // The shadow counter only advances when the IF/ID register actually moves.
  always_comb begin
    w_nextState   = r_state;
    w_nextKillCnt = r_killCnt;
    w_nextStall   = r_stall;
    w_nextFlush   = 1'b0;
    w_nextPc      = r_newPc;
    case (r_state)
      FLUSH: begin
        w_nextState = RUN;
        w_nextStall = '0;
        w_nextPc    = '0;
      end
      IDLE: begin
        if (int_i) begin
          w_nextState = FLUSH;
          w_nextStall = '0;
          w_nextFlush = 1'b1;
          w_nextPc    = w_intVec;
        end
      end
      default: begin
        if (excp_valid_i) begin
          w_nextState   = FLUSH;
          w_nextKillCnt = '0;
          w_nextStall   = '0;
          w_nextFlush   = 1'b1;
          w_nextPc      = w_excVec;
        end else if (ertn_i) begin
          w_nextState   = FLUSH;
          w_nextKillCnt = '0;
          w_nextStall   = '0;
          w_nextFlush   = 1'b1;
          w_nextPc      = era_i;
        end else if (idle_i) begin
          w_nextState   = IDLE;
          w_nextKillCnt = '0;
          w_nextStall   = '1;
        end else begin
          w_nextStall = w_stallMask;
          if (r_state == RUN && branch_i) begin
            w_nextState   = KILL;
            w_nextKillCnt = KILL_LOAD;
          end else if (r_state == KILL && !r_stall[1]) begin
            w_nextKillCnt = r_killCnt - 1'b1;
            if (r_killCnt == KW'(1)) w_nextState = RUN;
          end
        end
      end
    endcase
  end

  always_comb begin
    pc_kill_o = branch_i & (r_state == RUN);
    if_kill_o = pc_kill_o | (r_state == KILL);
  end

  assign stall_o  = r_stall;
  assign flush_o  = r_flush;
  assign new_pc_o = r_newPc;
  assign state_o  = r_state;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed vector table, asynchronous reset
// sequences, then randomized traffic against a behavioural reference model.
module tb_pipe_ctrl;

  localparam int BRK = 2;

  logic        clk;
  logic        rst_n;
  logic [6:0]  stallreq_i;
  logic        branch_i;
  logic        excp_valid_i;
  logic [3:0]  excp_code_i;
  logic        ertn_i;
  logic [31:0] era_i;
  logic        idle_i;
  logic        int_i;
  logic [6:0]  stall_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic        pc_kill_o;
  logic        if_kill_o;
  logic [1:0]  state_o;

  int checks = 0;
  int passed = 0;

  pipe_ctrl #(
    .STAGES(7), .ADDR_W(32), .ECODE_W(4), .BR_KILL(BRK)
  ) dut (
    .clk(clk), .rst_n(rst_n), .stallreq_i(stallreq_i), .branch_i(branch_i),
    .excp_valid_i(excp_valid_i), .excp_code_i(excp_code_i), .ertn_i(ertn_i),
    .era_i(era_i), .idle_i(idle_i), .int_i(int_i), .stall_o(stall_o),
    .flush_o(flush_o), .new_pc_o(new_pc_o), .pc_kill_o(pc_kill_o),
    .if_kill_o(if_kill_o), .state_o(state_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [6:0]  req;
    logic        br;
    logic        ex;
    logic [3:0]  code;
    logic        er;
    logic [31:0] era;
    logic        idl;
    logic        irq;
    logic [1:0]  eState;
    logic        ePk;
    logic        eIk;
    logic [6:0]  eStall;
    logic        eFlush;
    logic [31:0] ePc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(int req, int br, int ex, int code, int er, int era,
                              int idl, int irq, int eState, int ePk, int eIk,
                              int eStall, int eFlush, int ePc);
    vec_t v;
    v.req = 7'(req);     v.br = 1'(br);       v.ex = 1'(ex);
    v.code = 4'(code);   v.er = 1'(er);       v.era = 32'(era);
    v.idl = 1'(idl);     v.irq = 1'(irq);     v.eState = 2'(eState);
    v.ePk = 1'(ePk);     v.eIk = 1'(eIk);     v.eStall = 7'(eStall);
    v.eFlush = 1'(eFlush); v.ePc = 32'(ePc);
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic applyStimulus(input logic [6:0] req, input logic br, input logic ex,
                               input logic [3:0] code, input logic er, input logic [31:0] era,
                               input logic idl, input logic irq);
    stallreq_i = req; branch_i = br; excp_valid_i = ex; excp_code_i = code;
    ertn_i = er; era_i = era; idle_i = idl; int_i = irq;
  endtask

  // Reference model: pipeline mode as spec state code, remaining shadow cycles
  int          mMode;
  int          mShadow;
  logic [6:0]  mStall;
  logic        mFlush;
  logic [31:0] mPc;

  function automatic logic [6:0] freezeMask(logic [6:0] req);
    int k = -1;
    int m;
    for (int i = 0; i < 7; i++) if (req[i]) k = i;
    m = (k < 0) ? 0 : ((1 << (k + 1)) - 1);
    return 7'(m);
  endfunction

  task automatic modelReset();
    mMode = 0; mShadow = 0; mStall = 7'h0; mFlush = 1'b0; mPc = 32'h0;
  endtask

  task automatic modelStep();
    logic wasFrozen;
    wasFrozen = mStall[1];
    mFlush = 1'b0;
    if (mMode == 2) begin
      mPc = 32'h0; mStall = 7'h0; mMode = 0;
    end else if (mMode == 3) begin
      if (int_i) begin
        mPc = 32'd12; mFlush = 1'b1; mStall = 7'h0; mMode = 2;
      end
    end else if (excp_valid_i) begin
      mPc = 32'(12 + 64 * int'(excp_code_i)); mFlush = 1'b1; mStall = 7'h0;
      mMode = 2; mShadow = 0;
    end else if (ertn_i) begin
      mPc = era_i; mFlush = 1'b1; mStall = 7'h0; mMode = 2; mShadow = 0;
    end else if (idle_i) begin
      mStall = 7'h7f; mMode = 3; mShadow = 0;
    end else begin
      mStall = freezeMask(stallreq_i);
      if (mMode == 0 && branch_i) begin
        mShadow = BRK; mMode = 1;
      end else if (mMode == 1 && !wasFrozen) begin
        mShadow = mShadow - 1;
        if (mShadow == 0) mMode = 0;
      end
    end
  endtask

  logic prevFlush;

  initial begin
    rst_n = 1'b0;
    applyStimulus(7'h08, 1'b0, 1'b0, 4'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset stall_o", 32'(stall_o), 32'h0);
    checkOutput("reset flush_o", 32'(flush_o), 32'h0);
    checkOutput("reset new_pc_o", new_pc_o, 32'h0);
    checkOutput("reset state_o", 32'(state_o), 32'h0);
    checkOutput("reset pc_kill_o", 32'(pc_kill_o), 32'h0);
    checkOutput("reset if_kill_o", 32'(if_kill_o), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // req br ex code er era idl irq | state pk ik stall flush pc
    vecs.push_back(mk('h08,0,0,0,0,0,0,0, 0,0,0,'h0f,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,    0,0,0,0,0,0));
    vecs.push_back(mk(0,1,0,0,0,0,0,0,    0,1,1,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,    1,0,1,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,    1,0,1,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,    0,0,0,0,0,0));
    vecs.push_back(mk(0,1,0,0,0,0,0,0,    0,1,1,0,0,0));
    vecs.push_back(mk('h04,0,0,0,0,0,0,0, 1,0,1,'h07,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,    1,0,1,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,    1,0,1,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,    0,0,0,0,0,0));
    vecs.push_back(mk(0,1,1,3,0,0,0,0,    0,1,1,0,1,'hcc));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,    2,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,    0,0,0,0,0,0));
    vecs.push_back(mk(0,1,0,0,0,0,0,0,    0,1,1,0,0,0));
    vecs.push_back(mk(0,0,1,1,0,0,0,0,    1,0,1,0,1,'h4c));
    vecs.push_back(mk(0,1,0,0,0,0,0,0,    2,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,    0,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,1,'h1c000100,0,0, 0,0,0,0,1,'h1c000100));
    vecs.push_back(mk(0,0,0,0,1,'h1c000100,0,0, 2,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,    0,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,1,0,    0,0,0,'h7f,0,0));
    vecs.push_back(mk(0,1,0,0,0,0,0,0,    3,0,0,'h7f,0,0));
    vecs.push_back(mk(0,0,1,5,0,0,0,0,    3,0,0,'h7f,0,0));
    vecs.push_back(mk('h01,1,0,0,0,0,0,0, 3,0,0,'h7f,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,    3,0,0,'h7f,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,1,    3,0,0,0,1,'hc));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,    2,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,    0,0,0,0,0,0));
    vecs.push_back(mk(0,0,1,2,1,'h1234,1,0, 0,0,0,0,1,'h8c));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,    2,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,1,'habc,1,0, 0,0,0,0,1,'habc));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,    2,0,0,0,0,0));
    vecs.push_back(mk('h05,1,0,0,0,0,1,0, 0,1,1,'h7f,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,1,    3,0,0,0,1,'hc));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,    2,0,0,0,0,0));
    vecs.push_back(mk('h41,0,0,0,0,0,0,0, 0,0,0,'h7f,0,0));
    vecs.push_back(mk('h02,0,0,0,0,0,0,0, 0,0,0,'h03,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,    0,0,0,0,0,0));

    for (int r = 0; r < vecs.size(); r++) begin
      applyStimulus(vecs[r].req, vecs[r].br, vecs[r].ex, vecs[r].code,
                    vecs[r].er, vecs[r].era, vecs[r].idl, vecs[r].irq);
      #1;
      checkOutput($sformatf("row%0d state_o", r), 32'(state_o), 32'(vecs[r].eState));
      checkOutput($sformatf("row%0d pc_kill_o", r), 32'(pc_kill_o), 32'(vecs[r].ePk));
      checkOutput($sformatf("row%0d if_kill_o", r), 32'(if_kill_o), 32'(vecs[r].eIk));
      @(posedge clk);
      #1;
      checkOutput($sformatf("row%0d stall_o", r), 32'(stall_o), 32'(vecs[r].eStall));
      checkOutput($sformatf("row%0d flush_o", r), 32'(flush_o), 32'(vecs[r].eFlush));
      checkOutput($sformatf("row%0d new_pc_o", r), new_pc_o, vecs[r].ePc);
      @(negedge clk);
    end

    // Asynchronous reset in the middle of a branch shadow
    applyStimulus(7'h00, 1'b1, 1'b0, 4'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    applyStimulus(7'h04, 1'b0, 1'b0, 4'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("midkill stall_o before reset", 32'(stall_o), 32'h07);
    @(negedge clk);
    stallreq_i = 7'h00;
    #1 rst_n = 1'b0;
    #1;
    checkOutput("midkill async state_o", 32'(state_o), 32'h0);
    checkOutput("midkill async stall_o", 32'(stall_o), 32'h0);
    checkOutput("midkill async if_kill_o", 32'(if_kill_o), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    stallreq_i = 7'h08;
    @(posedge clk);
    #1;
    checkOutput("post-reset stall_o", 32'(stall_o), 32'h0f);
    checkOutput("post-reset state_o", 32'(state_o), 32'h0);
    @(negedge clk);
    stallreq_i = 7'h00;

    // Asynchronous reset while idle
    idle_i = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("idle state_o", 32'(state_o), 32'h3);
    @(negedge clk);
    idle_i = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    checkOutput("mididle async stall_o", 32'(stall_o), 32'h0);
    checkOutput("mididle async state_o", 32'(state_o), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("post-idle-reset state_o", 32'(state_o), 32'h0);
    checkOutput("post-idle-reset stall_o", 32'(stall_o), 32'h0);

    // Randomized traffic against the reference model
    @(negedge clk);
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    modelReset();
    prevFlush = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      applyStimulus(($urandom_range(0, 2) == 0) ? 7'($urandom) : 7'h00,
                    1'($urandom_range(0, 3) == 0),
                    1'($urandom_range(0, 19) == 0),
                    4'($urandom),
                    1'($urandom_range(0, 19) == 0),
                    $urandom,
                    1'($urandom_range(0, 24) == 0),
                    1'($urandom_range(0, 5) == 0));
      #1;
      checkOutput($sformatf("rnd%0d state_o", n), 32'(state_o), 32'(mMode));
      checkOutput($sformatf("rnd%0d pc_kill_o", n), 32'(pc_kill_o),
                  32'(branch_i && mMode == 0));
      checkOutput($sformatf("rnd%0d if_kill_o", n), 32'(if_kill_o),
                  32'((branch_i && mMode == 0) || mMode == 1));
      modelStep();
      @(posedge clk);
      #1;
      checkOutput($sformatf("rnd%0d stall_o", n), 32'(stall_o), 32'(mStall));
      checkOutput($sformatf("rnd%0d flush_o", n), 32'(flush_o), 32'(mFlush));
      checkOutput($sformatf("rnd%0d new_pc_o", n), new_pc_o, mPc);
      if (prevFlush) checkOutput($sformatf("rnd%0d flush_o after flush", n), 32'(flush_o), 32'h0);
      prevFlush = flush_o;
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Parametrised pipeline control unit for the in-order core: the next generation of the fixed 7-stage controller. It sequences stall, flush, branch-shadow kill and idle (wait-for-interrupt) for a pipeline of STAGES stages. It also computes the redirect PC for exceptions, interrupts and exception return. It sits beside the datapath and drives the per-stage enables and kill strobes of every pipeline register.

## Interface
- STAGES, 7: pipeline stages; stage 0 = PC, stage 1 = IF/ID, increasing downstream.
- ADDR_W, 32: PC width.
- ECODE_W, 4: exception code width.
- BR_KILL, 1: cycles of IF/ID kill after a resolved branch (1..7).
- EXC_BASE, 32'h0000_000c: exception vector base.
- VEC_STRIDE, 32'h40: byte distance between vectors.
- INT_CODE, 0: code used for interrupt entry.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- stallreq_i  in  STAGES  bit k = stage k requests a stall.
- branch_i  in  1  taken branch resolved in ID.
- excp_valid_i  in  1  exception committed.
- excp_code_i  in  ECODE_W  exception code.
- ertn_i  in  1  exception return committed.
- era_i  in  ADDR_W  return address for ertn.
- idle_i  in  1  idle instruction committed.
- int_i  in  1  pending unmasked interrupt (level).
- stall_o  out  STAGES  registered; bit k freezes stage k.
- flush_o  out  1  registered one-cycle flush of all stages.
- new_pc_o  out  ADDR_W  registered redirect PC, valid with flush_o.
- pc_kill_o  out  1  combinational; kills the fetch in the PC stage.
- if_kill_o  out  1  combinational; kills the IF/ID instruction.
- state_o  out  2  current state, for debug.

## Operation
- States:
  - RUN=0.
  - KILL=1.
  - FLUSH=2.
  - IDLE=3.
- Reset values:
  - state RUN, kill_cnt 0.
  - stall_o 0, flush_o 0, new_pc_o 0.
- Event priority, evaluated each cycle in RUN and KILL:
  1. excp_valid_i.
  2. ertn_i.
  3. idle_i.
  4. branch_i.
  5. stallreq_i.
- Exception:
  - new_pc_o <= EXC_BASE + excp_code_i*VEC_STRIDE; flush_o <= 1; stall_o <= 0.
  - Go to FLUSH; kill_cnt <= 0.
  - This preempts an active KILL.
- Exception return (ertn_i): new_pc_o <= era_i; flush_o <= 1; go to FLUSH.
- Idle (idle_i): stall_o <= all ones; go to IDLE.
- Branch:
  - In RUN only: kill_cnt <= BR_KILL; go to KILL.
  - branch_i in KILL is ignored.
- Stall:
  - Let k = highest set index of stallreq_i. Then stall_o <= (2^(k+1))-1, freezing stages 0..k.
  - With no request, stall_o <= 0.
  - In KILL, stalls are computed the same way and kill_cnt does not decrement while stall_o[1]=1.
- KILL: kill_cnt decrements each unstalled cycle; when it reaches 0, go to RUN.
- FLUSH:
  - Lasts exactly one cycle: flush_o <= 0, new_pc_o <= 0, then RUN.
  - All inputs are ignored in this cycle.
- IDLE:
  - stall_o stays all ones; excp, ertn, branch and stallreq are ignored.
  - On int_i=1: new_pc_o <= EXC_BASE + INT_CODE*VEC_STRIDE; flush_o <= 1; stall_o <= 0; go to FLUSH.
- Combinational kills:
  - pc_kill_o = branch_i & (state==RUN).
  - if_kill_o = pc_kill_o | (state==KILL).
- Arithmetic:
  - The vector computation is done in ADDR_W bits, wrapping modulo 2^ADDR_W.
  - kill_cnt is clog2(BR_KILL+1) bits wide.

## Timing
- All registered outputs appear 1 cycle after the sampled event.
- flush_o is never high for 2 consecutive cycles.
- pc_kill_o and if_kill_o respond in the same cycle as their inputs.
- A branch with BR_KILL=N:
  - if_kill_o is high for the branch cycle plus N further unstalled cycles.
  - pc_kill_o is high for the branch cycle only.
- excp_valid_i and branch_i in the same cycle: exception wins, kill_cnt is not loaded, and if_kill_o is still high that cycle.
- Reset asserted mid-KILL or mid-IDLE: all outputs return to reset values immediately (asynchronous); the first active edge after release evaluates from RUN.

## Test plan
- Reset and stall:
  - Stimulus: rst_n low, then stallreq_i=7'b0001000 for 1 cycle.
  - Required: all outputs 0 during reset; stall_o=7'b0001111 one cycle later, then 0.
- Branch shadow, BR_KILL=2:
  - Stimulus: branch_i pulse at cycle t.
  - Required: pc_kill_o high at t only; if_kill_o high at t, t+1, t+2; state back to RUN at t+3.
- Stall extends the shadow:
  - Stimulus: branch_i at t, stallreq_i[2]=1 at t+1.
  - Required: kill_cnt holds during cycle t+2; if_kill_o ends one cycle later than the unstalled case.
- Exception preempts a branch:
  - Stimulus: excp_valid_i=1, excp_code_i=3 with branch_i=1.
  - Required: next cycle flush_o=1, new_pc_o=32'h0000_00cc; the cycle after, flush_o=0 and state RUN.
- Exception return:
  - Stimulus: ertn_i=1 with era_i=32'h1c00_0100.
  - Required: flush_o=1 and new_pc_o=32'h1c00_0100 for exactly one cycle.
- Idle and wake:
  - Stimulus: idle_i pulse, branch_i pulses while idle, then int_i=1 five cycles later.
  - Required: stall_o=7'h7f throughout idle; branches ignored; on wake, flush_o=1, new_pc_o=32'h0000_000c, then stall_o=0.
